// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl: instruction-fetch sequencer.
// Owns the program counter and drives the async-read ROM address from it. Each
// fetched word is registered into a one-entry buffer that is handed to decode
// over a valid/ready handshake. Also handles start, jump/branch redirects, and
// halting on HALT_WORD.
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   start_i         leave IDLE and begin fetching
//   imem_addr_o     ROM address (= pc, combinational)
//   imem_rd_i       ROM read data for imem_addr_o
//   instr_o         buffered instruction
//   instr_pc_o      address instr_o was fetched from
//   instr_valid_o   buffer holds an unconsumed word
//   instr_ready_i   consumer takes instr_o this cycle
//   redirect_i      flush buffer and load redirect_pc_i
//   redirect_pc_i   redirect target (low log2(MEM_DEPTH) bits used)
//   halted_o        sequencer is in HALT
module instr_fetch_ctrl #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MEM_DEPTH = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [DATA_W-1:0] HALT_WORD = '1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic [DATA_W-1:0] imem_rd_i,
  output logic [DATA_W-1:0] instr_o,
  output logic [ADDR_W-1:0] instr_pc_o,
  output logic              instr_valid_o,
  input  logic              instr_ready_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic              halted_o
);

  // PC only needs enough bits to index the ROM; wrap-around is then free.
  localparam int unsigned PC_W = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t          state;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] target;
  logic            load_en;
  logic            is_halt;

  assign imem_addr_o = ADDR_W'(pc);
  assign target      = redirect_pc_i[PC_W-1:0];
  assign load_en     = !instr_valid_o || instr_ready_i;
  assign is_halt     = (imem_rd_i == HALT_WORD);

  // Upper target bits are deliberately discarded.
  generate
    if (ADDR_W > PC_W) begin : g_unused_target
      logic unused_target_hi;
      assign unused_target_hi = ^redirect_pc_i[ADDR_W-1:PC_W];
    end
  endgenerate

  // Sequencer state, PC and output buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      pc            <= PC_W'(RESET_PC);
      instr_o       <= '0;
      instr_pc_o    <= '0;
      instr_valid_o <= 1'b0;
      halted_o      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (redirect_i) pc <= target;
          if (start_i) state <= FETCH;
        end
        FETCH: begin
          if (redirect_i) begin
            // A handshake in this cycle still loses the stale word.
            instr_valid_o <= 1'b0;
            pc            <= target;
          end else if (load_en && is_halt) begin
            instr_valid_o <= 1'b0;
            state         <= HALT;
            halted_o      <= 1'b1;
          end else if (load_en) begin
            instr_o       <= imem_rd_i;
            instr_pc_o    <= ADDR_W'(pc);
            instr_valid_o <= 1'b1;
            pc            <= pc + PC_W'(1);
          end
        end
        HALT: begin
          if (redirect_i) begin
            pc       <= target;
            state    <= FETCH;
            halted_o <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: directed scenarios with literal expectations,
// then randomized traffic, all compared every cycle against a behavioural model.
module tb_instr_fetch_ctrl;

  localparam int DEPTH = 32;
  localparam logic [31:0] HALTW = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  imem_addr;
  logic [31:0] imem_rd;
  logic [31:0] instr;
  logic [7:0]  instr_pc;
  logic        valid;
  logic        ready = 1'b0;
  logic        redirect = 1'b0;
  logic [7:0]  redirect_pc = '0;
  logic        halted;

  logic [31:0] rom [DEPTH];

  int errors = 0;
  int checks = 0;
  bit armed  = 1'b0;

  // Behavioural model: mode 0=idle, 1=fetching, 2=halted.
  int          m_mode  = 0;
  int          m_pc    = 0;
  bit          m_valid = 1'b0;
  logic [31:0] m_instr = '0;
  int          m_ipc   = 0;

  always #5 clk = ~clk;

  assign imem_rd = rom[imem_addr[4:0]];

  instr_fetch_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start),
    .imem_addr_o   (imem_addr),
    .imem_rd_i     (imem_rd),
    .instr_o       (instr),
    .instr_pc_o    (instr_pc),
    .instr_valid_o (valid),
    .instr_ready_i (ready),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .halted_o      (halted)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model advances on each rising edge from the inputs present at that edge.
  always @(posedge clk) begin
    int          tgt;
    bit          take;
    logic [31:0] w;
    armed = 1'b1;
    if (rst) begin
      m_mode = 0; m_pc = 0; m_valid = 0; m_instr = '0; m_ipc = 0;
    end else begin
      tgt  = int'(redirect_pc) % DEPTH;
      take = !m_valid || ready;
      w    = rom[m_pc];
      if (m_mode == 0) begin
        if (redirect) m_pc = tgt;
        if (start) m_mode = 1;
      end else if (m_mode == 1) begin
        if (redirect) begin
          m_valid = 0;
          m_pc    = tgt;
        end else if (take && w == HALTW) begin
          m_valid = 0;
          m_mode  = 2;
        end else if (take) begin
          m_instr = w;
          m_ipc   = m_pc;
          m_valid = 1;
          m_pc    = (m_pc + 1) % DEPTH;
        end
      end else if (redirect) begin
        m_pc   = tgt;
        m_mode = 1;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (armed) begin
      chk("cmp_addr",   32'(imem_addr), 32'(m_pc));
      chk("cmp_valid",  32'(valid),     32'(m_valid));
      chk("cmp_halted", 32'(halted),    32'(m_mode == 2));
      chk("cmp_instr",  instr,          m_instr);
      chk("cmp_ipc",    32'(instr_pc),  32'(m_ipc));
    end
  end

  // Wait (bounded) until a valid word at address a is on the output.
  task automatic wait_pc(input int a, input int lim);
    bit found = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (valid && int'(instr_pc) == a) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) chk("timeout_wait_pc", 32'(0), 32'(1));
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) rom[i] = 32'(i + 100);

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_valid",  32'(valid),     32'(0));
    chk("rst_instr",  instr,          32'(0));
    chk("rst_halted", 32'(halted),    32'(0));
    chk("rst_addr",   32'(imem_addr), 32'(0));

    // 1: streaming from 0 with ready high.
    rst = 0; start = 1; ready = 1;
    @(negedge clk);
    start = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t1_instr", instr, 32'(100 + k));
      chk("t1_ipc",   32'(instr_pc), 32'(k));
    end

    // 2: stall three cycles on the word from address 5.
    wait_pc(5, 20);
    chk("t2_first", instr, 32'd105);
    ready = 0;
    repeat (3) begin
      @(negedge clk);
      chk("t2_hold_instr", instr, 32'd105);
      chk("t2_hold_addr",  32'(imem_addr), 32'd6);
    end
    ready = 1;
    @(negedge clk);
    chk("t2_next", instr, 32'd106);

    // 3: redirect to 0x1F then wrap to 0.
    wait_pc(7, 20);
    redirect = 1; redirect_pc = 8'h1F;
    @(negedge clk);
    redirect = 0;
    chk("t3_bubble", 32'(valid), 32'(0));
    @(negedge clk);
    chk("t3_w31", instr, 32'd131);
    chk("t3_p31", 32'(instr_pc), 32'd31);
    @(negedge clk);
    chk("t3_w0", instr, 32'd100);
    chk("t3_p0", 32'(instr_pc), 32'd0);

    // 4: HALT_WORD at address 4, then redirect out of HALT.
    rst = 1; rom[4] = HALTW;
    @(negedge clk);
    rst = 0; start = 1;
    @(negedge clk);
    start = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t4_word", instr, 32'(100 + k));
    end
    @(negedge clk);
    chk("t4_valid",  32'(valid),     32'(0));
    chk("t4_halted", 32'(halted),    32'(1));
    chk("t4_addr",   32'(imem_addr), 32'd4);
    redirect = 1; redirect_pc = 8'd10;
    @(negedge clk);
    redirect = 0;
    @(negedge clk);
    chk("t4_resume", instr, 32'd110);
    chk("t4_rpc",    32'(instr_pc), 32'd10);
    chk("t4_unhalt", 32'(halted), 32'(0));
    rom[4] = 32'd104;

    // 5: reset mid-stream, then no fetch without start.
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("t5_valid", 32'(valid), 32'(0));
    chk("t5_addr",  32'(imem_addr), 32'(0));
    repeat (3) begin
      @(negedge clk);
      chk("t5_idle_valid", 32'(valid), 32'(0));
    end

    // 6: start together with redirect to 0x23 -> address 3.
    start = 1; redirect = 1; redirect_pc = 8'h23;
    @(negedge clk);
    start = 0; redirect = 0;
    @(negedge clk);
    chk("t6_word", instr, 32'd103);
    chk("t6_ipc",  32'(instr_pc), 32'd3);

    // Randomized traffic; the per-cycle compare does the checking.
    for (int i = 0; i < DEPTH; i++)
      rom[i] = ($urandom % 16 == 0) ? HALTW : $urandom;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      ready       = ($urandom % 4) != 0;
      redirect    = ($urandom % 12) == 0;
      redirect_pc = 8'($urandom);
      start       = ($urandom % 8) == 0;
      rst         = ($urandom % 250) == 0;
      if (c % 500 == 499) rom[$urandom % DEPTH] = $urandom;
    end
    rst = 0; redirect = 0; start = 0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
